// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Initiator side of a word-indexed data-memory interface.
//                Accepts byte/half/word loads and stores on a valid/ready
//                handshake. Sub-word stores use read-modify-write, loads are
//                sign- or zero-extended, and misaligned or out-of-range
//                requests return an error without touching memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // Number of byte-address bits that fall inside the memory.
  localparam int BYTE_AW = ADDR_W + 2;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [BYTE_AW-1:0]   addr_q, addr_d;
  logic [1:0]           size_q, size_d;
  logic                 we_q, we_d;
  logic                 signed_q, signed_d;
  logic [31:0]          wdata_q, wdata_d;   // store data, later the merged word
  logic [31:0]          rdata_q, rdata_d;   // extended load result
  logic                 err_q, err_d;

  logic                 req_err;
  logic [7:0]           lane_byte;
  logic [15:0]          lane_half;
  logic [31:0]          load_value;
  logic [31:0]          merged_word;

  // Reject illegal size, misalignment, or any address bit above the memory.
  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11) req_err = 1'b1;
    if (req_size == SIZE_HALF && req_addr[0]) req_err = 1'b1;
    if (req_size == SIZE_WORD && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if ((req_addr >> BYTE_AW) != 32'd0) req_err = 1'b1;
  end

  // Select the addressed lane of the returned word and extend it.
  always_comb begin
    lane_byte = 8'h00;
    case (addr_q[1:0])
      2'd0: lane_byte = mem_rdata[7:0];
      2'd1: lane_byte = mem_rdata[15:8];
      2'd2: lane_byte = mem_rdata[23:16];
      2'd3: lane_byte = mem_rdata[31:24];
      default: lane_byte = 8'h00;
    endcase
    lane_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      SIZE_BYTE: load_value = {{24{signed_q & lane_byte[7]}}, lane_byte};
      SIZE_HALF: load_value = {{16{signed_q & lane_half[15]}}, lane_half};
      default:   load_value = mem_rdata;
    endcase
  end

  // Insert the new byte/half into the old word, leaving other lanes intact.
  always_comb begin
    merged_word = mem_rdata;
    if (size_q == SIZE_BYTE) begin
      case (addr_q[1:0])
        2'd0: merged_word[7:0]   = wdata_q[7:0];
        2'd1: merged_word[15:8]  = wdata_q[7:0];
        2'd2: merged_word[23:16] = wdata_q[7:0];
        2'd3: merged_word[31:24] = wdata_q[7:0];
        default: merged_word = mem_rdata;
      endcase
    end else begin
      if (addr_q[1]) merged_word[31:16] = wdata_q[15:0];
      else           merged_word[15:0]  = wdata_q[15:0];
    end
  end

  // Next-state and request-register update.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    we_d     = we_q;
    signed_d = signed_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr[BYTE_AW-1:0];
          size_d   = req_size;
          we_d     = req_we;
          signed_d = req_signed;
          wdata_d  = req_wdata;
          rdata_d  = 32'd0;
          err_d    = req_err;
          if (req_err)                           state_d = ST_RESP;
          else if (req_we && req_size == SIZE_WORD) state_d = ST_WRITE;
          else                                   state_d = ST_READ;
        end
      end
      ST_READ: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        if (we_q) begin
          wdata_d = merged_word;
          state_d = ST_WRITE;
        end else begin
          rdata_d = load_value;
          state_d = ST_RESP;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and request registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      size_q   <= 2'b00;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      we_q     <= we_d;
      signed_q <= signed_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Moore outputs decoded from state and the registered request.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_RESP);
    resp_rdata = (state_q == ST_RESP) ? rdata_q : 32'd0;
    resp_err   = (state_q == ST_RESP) & err_q;
    mem_read   = (state_q == ST_READ);
    mem_write  = (state_q == ST_WRITE);
    mem_addr   = (state_q == ST_READ || state_q == ST_WRITE)
                 ? addr_q[BYTE_AW-1:2] : '0;
    mem_wdata  = (state_q == ST_WRITE) ? wdata_q : 32'd0;
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Directed self-checking bench for load_store_unit with a
//                registered-read word memory preloaded with mem[i] = i+1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  logic [31:0] mem [0:31];

  int checks = 0;
  int errors = 0;

  // Results of the most recent transaction.
  int          lat;
  int          n_rd;
  int          n_wr;
  logic [31:0] got_rdata;
  logic        got_err;
  logic        timed_out;
  logic        both_hi;
  logic [4:0]  rd_addr;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  load_store_unit #(.ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = i + 1;
  end

  always @(posedge clk) begin
    if (mem_read)  mem_rdata <= mem[mem_addr];
    if (mem_write) mem[mem_addr] <= mem_wdata;
  end

  // Present one request from IDLE and observe it until its response.
  task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size;
    req_signed = sgn; req_addr = addr; req_wdata = wdata;
    lat = 0; n_rd = 0; n_wr = 0; got_rdata = 32'hx; got_err = 1'bx;
    timed_out = 1'b1; both_hi = 1'b0;
    rd_addr = 5'd0; wr_addr = 5'd0; wr_data = 32'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      lat++;
      if (mem_read && mem_write) both_hi = 1'b1;
      if (mem_read)  begin n_rd++; rd_addr = mem_addr; end
      if (mem_write) begin n_wr++; wr_addr = mem_addr; wr_data = mem_wdata; end
      if (resp_valid) begin
        got_rdata = resp_rdata; got_err = resp_err; timed_out = 1'b0;
        break;
      end
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'd0) begin
      errors++; $display("FAIL reset_resp got v=%b e=%b d=%h exp 0 0 0", resp_valid, resp_err, resp_rdata); end
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 5'd0 || mem_wdata !== 32'd0) begin
      errors++; $display("FAIL reset_mem got r=%b w=%b a=%h d=%h exp 0", mem_read, mem_write, mem_addr, mem_wdata); end
  endtask

  task automatic test_word_load();
    run_req(1'b0, 2'b10, 1'b0, 32'h08, 32'd0);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL lw_timeout got no resp exp resp"); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL lw_latency got %0d exp 3", lat); end
    checks++; if (got_rdata !== 32'h3 || got_err !== 1'b0) begin
      errors++; $display("FAIL lw_data got %h err %b exp 00000003 err 0", got_rdata, got_err); end
    checks++; if (n_rd !== 1 || rd_addr !== 5'd2 || n_wr !== 0) begin
      errors++; $display("FAIL lw_mem got rd=%0d addr=%0d wr=%0d exp 1 2 0", n_rd, rd_addr, n_wr); end
  endtask

  task automatic test_word_store();
    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h800000F0);
    checks++; if (lat !== 2 || got_err !== 1'b0 || got_rdata !== 32'd0) begin
      errors++; $display("FAIL sw_resp got lat=%0d err=%b d=%h exp 2 0 0", lat, got_err, got_rdata); end
    checks++; if (n_wr !== 1 || n_rd !== 0 || wr_addr !== 5'd4) begin
      errors++; $display("FAIL sw_mem got wr=%0d rd=%0d addr=%0d exp 1 0 4", n_wr, n_rd, wr_addr); end
    checks++; if (mem[4] !== 32'h800000F0) begin errors++; $display("FAIL sw_word got %h exp 800000f0", mem[4]); end
    run_req(1'b0, 2'b00, 1'b1, 32'h10, 32'd0);
    checks++; if (got_rdata !== 32'hFFFFFFF0) begin errors++; $display("FAIL lb got %h exp fffffff0", got_rdata); end
    run_req(1'b0, 2'b00, 1'b0, 32'h10, 32'd0);
    checks++; if (got_rdata !== 32'h000000F0) begin errors++; $display("FAIL lbu got %h exp 000000f0", got_rdata); end
    run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'd0);
    checks++; if (got_rdata !== 32'hFFFF8000) begin errors++; $display("FAIL lh got %h exp ffff8000", got_rdata); end
    run_req(1'b0, 2'b01, 1'b0, 32'h12, 32'd0);
    checks++; if (got_rdata !== 32'h00008000) begin errors++; $display("FAIL lhu got %h exp 00008000", got_rdata); end
    run_req(1'b0, 2'b00, 1'b1, 32'h13, 32'd0);
    checks++; if (got_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_lane3 got %h exp ffffff80", got_rdata); end
  endtask

  task automatic test_subword_store();
    run_req(1'b1, 2'b00, 1'b0, 32'h05, 32'h000000AB);
    checks++; if (lat !== 4 || got_err !== 1'b0) begin
      errors++; $display("FAIL sb_latency got %0d err %b exp 4 0", lat, got_err); end
    checks++; if (n_rd !== 1 || n_wr !== 1 || rd_addr !== 5'd1 || wr_addr !== 5'd1 || wr_data !== 32'h0000AB02) begin
      errors++; $display("FAIL sb_rmw got rd=%0d wr=%0d ra=%0d wa=%0d wd=%h exp 1 1 1 1 0000ab02",
                         n_rd, n_wr, rd_addr, wr_addr, wr_data); end
    run_req(1'b0, 2'b10, 1'b0, 32'h04, 32'd0);
    checks++; if (got_rdata !== 32'h0000AB02) begin errors++; $display("FAIL sb_readback got %h exp 0000ab02", got_rdata); end
    run_req(1'b1, 2'b01, 1'b0, 32'h1A, 32'h1234BEEF);
    checks++; if (lat !== 4 || wr_data !== 32'hBEEF0007 || mem[6] !== 32'hBEEF0007) begin
      errors++; $display("FAIL sh_upper got lat=%0d wd=%h mem=%h exp 4 beef0007", lat, wr_data, mem[6]); end
    run_req(1'b0, 2'b01, 1'b0, 32'h1A, 32'd0);
    checks++; if (got_rdata !== 32'h0000BEEF) begin errors++; $display("FAIL lhu_upper got %h exp 0000beef", got_rdata); end
  endtask

  task automatic test_errors();
    logic        e_we   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  e_size [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
    logic [31:0] e_addr [4] = '{32'h06, 32'h03, 32'h00, 32'h80};
    for (int i = 0; i < 4; i++) begin
      run_req(e_we[i], e_size[i], 1'b0, e_addr[i], 32'hFFFFFFFF);
      checks++;
      if (lat !== 1 || got_err !== 1'b1 || got_rdata !== 32'd0 || n_rd !== 0 || n_wr !== 0) begin
        errors++;
        $display("FAIL err_case%0d got lat=%0d err=%b d=%h rd=%0d wr=%0d exp 1 1 0 0 0",
                 i, lat, got_err, got_rdata, n_rd, n_wr);
      end
    end
    checks++; if (mem[1] !== 32'h0000AB02 || mem[0] !== 32'h1) begin
      errors++; $display("FAIL err_nowrite got m0=%h m1=%h exp 00000001 0000ab02", mem[0], mem[1]); end
  endtask

  task automatic test_back_to_back();
    logic        rdy [1:12];
    logic        rv  [1:12];
    logic [31:0] rd  [1:12];
    int          pulses;
    int          busy;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h08; req_wdata = 32'h00000011;
    @(posedge clk);
    #1 req_we = 1'b0; req_size = 2'b10;   // second request: word load of 0x08
    pulses = 0; busy = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      rdy[k] = req_ready; rv[k] = resp_valid; rd[k] = resp_rdata;
      if (resp_valid) pulses++;
      if (k <= 5 && !req_ready) busy++;
      if (k == 6) req_valid = 1'b0;
    end
    checks++; if (busy !== 4 || rdy[5] !== 1'b1) begin
      errors++; $display("FAIL b2b_ready got busy=%0d rdy5=%b exp 4 1", busy, rdy[5]); end
    checks++; if (pulses !== 2 || rv[4] !== 1'b1 || rv[8] !== 1'b1) begin
      errors++; $display("FAIL b2b_pulses got n=%0d at4=%b at8=%b exp 2 1 1", pulses, rv[4], rv[8]); end
    checks++; if (rd[8] !== 32'h00000011 || mem[2] !== 32'h00000011) begin
      errors++; $display("FAIL b2b_data got %h mem %h exp 00000011", rd[8], mem[2]); end
  endtask

  task automatic test_async_reset();
    logic seen_resp;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h0C; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL rst_pre_write got %b exp 1", mem_write); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (mem_write !== 1'b0 || mem_wdata !== 32'd0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_drop got w=%b d=%h v=%b exp 0 0 0", mem_write, mem_wdata, resp_valid); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_resp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (resp_valid) seen_resp = 1'b1;
    end
    checks++; if (mem[3] !== 32'h4 || seen_resp !== 1'b0) begin
      errors++; $display("FAIL rst_abort got mem=%h resp=%b exp 00000004 0", mem[3], seen_resp); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", req_ready); end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_word_load();
    test_word_store();
    test_subword_store();
    test_errors();
    test_back_to_back();
    test_async_reset();
    checks++; if (both_hi !== 1'b0) begin errors++; $display("FAIL rd_wr_overlap got 1 exp 0"); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
